// File: rtl/moving_avg_fir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moving_avg_fir: push-button-controlled moving-average FIR over a window  |
// | of 2**LOG2_TAPS signed samples. Define FIR_LFSR_SRC_EN to add an internal |
// | 16-bit LFSR sample source selected by src_sel.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module moving_avg_fir #(
  parameter int WIDTH     = 8,
  parameter int LOG2_TAPS = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             toggleBtn,
  input  logic             src_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             running,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int c_taps = 2**LOG2_TAPS;
  localparam int c_aw   = WIDTH + LOG2_TAPS;
  localparam int c_cw   = LOG2_TAPS + 1;
  localparam logic [c_cw-1:0] c_cnt_full = c_cw'(c_taps);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_taps - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_btn_s1;
  logic                       r_btn_s2;
  logic                       r_btn_s3;
  logic                       w_press;
  logic                       w_start;
  logic                       w_accept;
  logic                       w_emit;
  logic                       w_src_valid;
  logic [WIDTH-1:0]           w_sample;
  logic [c_taps-1:0][WIDTH-1:0] r_line;
  logic signed [c_aw-1:0]     r_acc;
  logic signed [c_aw-1:0]     w_new_ext;
  logic signed [c_aw-1:0]     w_old_ext;
  logic signed [c_aw-1:0]     w_acc_next;
  logic signed [c_aw-1:0]     w_avg_full;
  logic [c_cw-1:0]            r_count;
  logic                       r_out_valid;
  logic [WIDTH-1:0]           r_out_data;

  // Two flops to synchronize, a third to see the falling edge of the button.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_s3 <= 1'b0;
    end else begin
      r_btn_s1 <= toggleBtn;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
    end
  end

  assign w_press = r_btn_s3 & ~r_btn_s2;
  assign w_start = (r_state == S_IDLE) & w_press;

`ifdef FIR_LFSR_SRC_EN
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_poly = 16'hB400;

  logic [15:0] r_lfsr;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_lfsr <= c_lfsr_seed;
    end else if (r_state != S_IDLE) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_poly : 16'h0000);
    end
  end

  assign w_sample    = src_sel ? r_lfsr[WIDTH-1:0] : in_data;
  assign w_src_valid = src_sel | in_valid;
`else
  logic w_unused_src_sel;
  assign w_unused_src_sel = src_sel;
  assign w_sample         = in_data;
  assign w_src_valid      = in_valid;
`endif

  // A press in the same cycle always wins over a sample.
  assign w_accept = (r_state != S_IDLE) & ~w_press & w_src_valid;
  assign w_emit   = w_accept & (r_count >= c_cnt_last);

  assign w_new_ext  = {{LOG2_TAPS{w_sample[WIDTH-1]}}, w_sample};
  assign w_old_ext  = {{LOG2_TAPS{r_line[c_taps-1][WIDTH-1]}}, r_line[c_taps-1]};
  assign w_acc_next = r_acc + w_new_ext - w_old_ext;
  assign w_avg_full = w_acc_next >>> LOG2_TAPS;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_press) w_state_next = S_FILL;
      end
      S_FILL: begin
        if (w_press) begin
          w_state_next = S_IDLE;
        end else if (w_accept && (r_count == c_cnt_last)) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_press) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_line <= '0;
    end else if (w_start) begin
      r_line <= '0;
    end else if (w_accept) begin
      r_line <= {r_line[c_taps-2:0], w_sample};
    end
  end

  // Output data only moves with out_valid, so it holds through IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_start) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_acc <= w_acc_next;
        if (r_count != c_cnt_full) r_count <= r_count + c_cw'(1);
      end
      if (w_emit) r_out_data <= w_avg_full[WIDTH-1:0];
    end
  end

  assign running   = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_moving_avg_fir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_moving_avg_fir: directed self-checking bench for moving_avg_fir       |
// | (WIDTH=8, LOG2_TAPS=2; LFSR steps only when FIR_LFSR_SRC_EN is defined). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_moving_avg_fir;

  localparam int WIDTH     = 8;
  localparam int LOG2_TAPS = 2;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             toggleBtn;
  logic             src_sel;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             running;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  int total = 0;
  int bad   = 0;

  moving_avg_fir #(
    .WIDTH     (WIDTH),
    .LOG2_TAPS (LOG2_TAPS)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .toggleBtn (toggleBtn),
    .src_sel   (src_sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .running   (running),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One sample offered for one clock; outputs are then sampled on the negedge.
  task automatic feed(input int v);
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  // Button low for two clocks so the synchronized edge fires; returns after the
  // clock on which the state has changed.
  task automatic press();
    toggleBtn = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    toggleBtn = 1'b1;
    @(negedge Clk);
  endtask

  task automatic feed_chk(input string tag, input int v, input logic ov, input int d);
    feed(v);
    chk({tag, "_valid"}, 32'(out_valid), 32'(ov));
    if (ov) chk({tag, "_data"}, $signed(out_data), d);
  endtask

  initial begin
    Reset_n   = 1'b0;
    toggleBtn = 1'b1;
    src_sel   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(negedge Clk);
    chk("rst_running", 32'(running), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", $signed(out_data), 0);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    feed_chk("idle_ignore", 50, 1'b0, 0);
    chk("idle_running", 32'(running), 0);

    // Warm-up
    press();
    chk("start_running", 32'(running), 1);
    feed_chk("warm1", 4, 1'b0, 0);
    feed_chk("warm2", 8, 1'b0, 0);
    feed_chk("warm3", 12, 1'b0, 0);
    feed_chk("warm4", 16, 1'b1, 10);
    @(negedge Clk);
    chk("strobe_single", 32'(out_valid), 0);
    feed_chk("warm5", 20, 1'b1, 14);

    // Negative rounding (window 8,12,16,20 slides out)
    feed_chk("neg1", -1, 1'b1, 11);
    feed_chk("neg2", -1, 1'b1, 8);
    feed_chk("neg3", -1, 1'b1, 4);
    feed_chk("neg4", -2, 1'b1, -2);

    // Extremes
    feed_chk("max1", 127, 1'b1, 30);
    feed_chk("max2", 127, 1'b1, 62);
    feed_chk("max3", 127, 1'b1, 94);
    feed_chk("max4", 127, 1'b1, 127);
    feed_chk("min1", -128, 1'b1, 63);
    feed_chk("min2", -128, 1'b1, -1);
    feed_chk("min3", -128, 1'b1, -65);
    feed_chk("min4", -128, 1'b1, -128);

    // Stop / restart: stale samples must not contribute
    feed_chk("pre1", 100, 1'b1, -71);
    feed_chk("pre2", 100, 1'b1, -14);
    press();
    chk("stop_running", 32'(running), 0);
    feed_chk("stop_ignore", 60, 1'b0, 0);
    chk("stop_hold", $signed(out_data), -14);
    press();
    chk("restart_running", 32'(running), 1);
    feed_chk("re1", 1, 1'b0, 0);
    feed_chk("re2", 2, 1'b0, 0);
    feed_chk("re3", 3, 1'b0, 0);
    feed_chk("re4", 6, 1'b1, 3);

    // Press coincident with a sample: the sample is dropped
    toggleBtn = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    toggleBtn = 1'b1;
    in_valid  = 1'b1;
    in_data   = WIDTH'(100);
    @(negedge Clk);
    in_valid = 1'b0;
    chk("coll_valid", 32'(out_valid), 0);
    chk("coll_data", $signed(out_data), 3);
    chk("coll_running", 32'(running), 0);

    // Mid-run asynchronous reset
    press();
    feed_chk("r1", 4, 1'b0, 0);
    feed_chk("r2", 4, 1'b0, 0);
    feed_chk("r3", 4, 1'b0, 0);
    feed_chk("r4", 8, 1'b1, 5);
    feed_chk("r5", 12, 1'b1, 7);
    Reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", $signed(out_data), 0);
    chk("arst_running", 32'(running), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    feed_chk("post_rst_idle", 9, 1'b0, 0);
    chk("post_rst_running", 32'(running), 0);

`ifdef FIR_LFSR_SRC_EN
    // LFSR samples E1,70,38,9C -> -31+112+56-100 = 37 -> 9
    src_sel = 1'b1;
    press();
    @(negedge Clk);
    chk("lfsr_c1", 32'(out_valid), 0);
    @(negedge Clk);
    chk("lfsr_c2", 32'(out_valid), 0);
    @(negedge Clk);
    chk("lfsr_c3", 32'(out_valid), 0);
    @(negedge Clk);
    chk("lfsr_c4_valid", 32'(out_valid), 1);
    chk("lfsr_c4_data", $signed(out_data), 9);
    src_sel = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
